apb_master: RTL and testbench
=============================

# apb_master

Single-outstanding APB3 requester. It converts a simple valid/ready command stream into IDLE→SETUP→ACCESS bus transfers toward `apb_slave`, and returns read data and error status on a one-cycle response strobe. It is the initiator end of the APB interface, used by bus bridges and by the APB slave's own regression environment.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, width of `paddr` and `cmd_addr`
- `DATA_WIDTH`, 32, width of all data buses
- `TIMEOUT_CYCLES`, 16, maximum ACCESS wait cycles; used only when `APB_MASTER_TIMEOUT_EN` is defined

Ports:
- `pclk` in 1: the only clock; all logic is on the rising edge
- `preset` in 1: reset, asynchronous and active-high
- `cmd_valid` in 1: a command is presented
- `cmd_ready` out 1: the command is accepted on a rising edge where valid && ready
- `cmd_write` in 1: 1 = write, 0 = read
- `cmd_addr` in ADDR_WIDTH: transfer address
- `cmd_wdata` in DATA_WIDTH: write data
- `rsp_valid` out 1: one-cycle completion strobe; there is no backpressure
- `rsp_rdata` out DATA_WIDTH: read data, valid with `rsp_valid`; 0 for writes
- `rsp_err` out 1: the transfer ended with `pslverr`, or timed out
- `paddr` out ADDR_WIDTH, `pwdata` out DATA_WIDTH, `pwrite` out 1, `psel` out 1, `penable` out 1: APB request signals
- `prdata` in DATA_WIDTH, `pready` in 1, `pslverr` in 1: APB completer response signals

## Operation
- States (in `apb_pkg`): IDLE, SETUP, ACCESS.
- IDLE:
  - `psel`=0, `penable`=0.
  - On an accepted command: latch write, address and data into `paddr`/`pwrite`/`pwdata`, then go to SETUP.
- SETUP:
  - `psel`=1, `penable`=0.
  - Always go to ACCESS on the next edge.
- ACCESS:
  - `psel`=1, `penable`=1; the address, data and direction are held stable.
  - If `pready`=0, stay in ACCESS (wait state).
  - If `pready`=1, the transfer completes. Capture `prdata` (reads only) and `pslverr`.
  - After completion: if a command is accepted in the same cycle, go directly to SETUP (back-to-back transfer, `psel` stays high); otherwise go to IDLE.
- `cmd_ready` = (state==IDLE) || (state==ACCESS && pready). This is combinational on `pready`.
- `pready` and `pslverr` are ignored outside ACCESS.
- Write completion: `rsp_rdata`=0, `rsp_err`=`pslverr`.
- Reset values:
  - state=IDLE
  - `psel`, `penable`, `pwrite`, `rsp_valid`, `rsp_err` = 0
  - `paddr`, `pwdata`, `rsp_rdata` = 0
  - `cmd_ready`=1 as soon as reset deasserts
- Reset asserted mid-transfer: the bus drops to IDLE immediately (asynchronously) and no response is issued for the aborted transfer.

## Timing
- Command accepted at edge T → SETUP during cycle T..T+1 → ACCESS from edge T+1.
- With zero wait states: completion at edge T+2, and `rsp_valid` is high for the cycle after edge T+2.
- Each cycle of `pready`=0 adds one cycle of latency.
- Back-to-back throughput: one transfer per 2 cycles.
- `rsp_valid` is registered and high for exactly one cycle per completed transfer.
- `rsp_rdata` and `rsp_err` hold their values until the next completion.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments on each edge with `pready`=0.
  - When the count reaches `TIMEOUT_CYCLES`, the transfer is forced to complete with `rsp_err`=1 and `rsp_rdata`=0, then the block returns to IDLE.
  - No back-to-back transfer is taken on a timeout; `cmd_ready`=0 in that cycle.
  - If `pready` rises on the same edge as the timeout, the real completion wins.
- Not defined: the counter is absent and ACCESS waits on `pready` indefinitely.

## Structure
- `apb_pkg` holds:
  - the state enum
  - default `ADDR_WIDTH`/`DATA_WIDTH`, shared with `apb_slave`
  - the `TIMEOUT_CYCLES` default
- Sub-module `apb_wait_timer` holds the timeout counter with clear, enable and expired ports. It is instantiated only under `APB_MASTER_TIMEOUT_EN`.

## Test plan
- Write then read back, zero waits, address 0x155, data 0xDEADBEEF:
  - write: `psel` high for 2 cycles, `penable` high for 1 cycle, `rsp_valid` 3 cycles after acceptance, `rsp_err`=0
  - read: `rsp_rdata`=0xDEADBEEF
- Read with `pready` held low for 3 ACCESS cycles: `paddr`, `pwrite` and `psel` remain stable; `rsp_valid` arrives 6 cycles after acceptance.
- Two commands with `cmd_valid` held high: the second SETUP immediately follows the first ACCESS with no IDLE cycle; two `rsp_valid` pulses, 2 cycles apart.
- Slave responds `pslverr`=1 on a write to 0x3FF: `rsp_err`=1 for that response; the next clean transfer returns `rsp_err`=0.
- Assert `preset` during ACCESS: `psel` and `penable` drop to 0 immediately with no `rsp_valid`; after release, a fresh command completes normally.
- With `APB_MASTER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, `pready` tied low: `rsp_err`=1 and `rsp_rdata`=0 after 16 wait cycles, then IDLE with `cmd_ready`=1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer-phase state enum and default bus geometry,
// common to apb_master and apb_slave.
package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH     = 10;
    localparam int unsigned APB_DATA_WIDTH     = 32;
    localparam int unsigned APB_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter for apb_master; expired is a registered flag set
// once TIMEOUT_CYCLES wait edges have elapsed since the last clear.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic pclk,
    input  logic preset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    // Saturates at the limit so expired cannot wrap back to zero
    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (en && !expired) begin
            count_nxt = count + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            count   <= count_nxt;
            expired <= (count_nxt == CNT_W'(TIMEOUT_CYCLES));
        end
    end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB3 requester: valid/ready commands in, IDLE/SETUP/ACCESS
// transfers out, one-cycle response strobe back. Define APB_MASTER_TIMEOUT_EN
// to bound ACCESS wait states with apb_wait_timer.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    apb_state_e state;
    apb_state_e state_nxt;
    logic       accept_c;
    logic       done_c;
    logic       timeout_c;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be nonzero");
    end

    // Ready is combinational on pready so a completing ACCESS can chain into SETUP
    assign cmd_ready = (state == IDLE) || ((state == ACCESS) && pready);
    assign accept_c  = cmd_valid && cmd_ready;
    assign done_c    = (state == ACCESS) && pready;

`ifdef APB_MASTER_TIMEOUT_EN
    logic tmr_expired;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .pclk   (pclk),
        .preset (preset),
        .clear  (state == SETUP),
        .en     ((state == ACCESS) && !pready),
        .expired(tmr_expired)
    );

    // A real completion on the expiry edge takes precedence
    assign timeout_c = (state == ACCESS) && !pready && tmr_expired;
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (done_c) begin
                    state_nxt = accept_c ? SETUP : IDLE;
                end else if (timeout_c) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bus request: phase strobes follow the next state, payload loads on acceptance
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
        end else begin
            psel    <= (state_nxt != IDLE);
            penable <= (state_nxt == ACCESS);
            if (accept_c) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
            end
        end
    end

    // Response: one-cycle strobe, data/status held until the next completion
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= done_c || timeout_c;
            if (done_c) begin
                rsp_rdata <= pwrite ? '0 : prdata;
                rsp_err   <= pslverr;
            end else if (timeout_c) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: behavioural APB completer with a word
// memory, and an in-order transaction model for expected responses.
module tb_apb_master;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LOGN = 4096;
    localparam logic [AW-1:0] ERR_ADDR = 10'h3FF;

    logic          pclk = 1'b0;
    logic          preset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;
    logic          cmd_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite;
    logic          psel;
    logic          penable;

    apb_master dut (
        .pclk     (pclk),
        .preset   (preset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pwrite   (pwrite),
        .psel     (psel),
        .penable  (penable),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    always #5 pclk = ~pclk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int            acc_q[$];
    int            rsp_cyc_q[$];
    logic [DW-1:0] rsp_data_q[$];
    logic          rsp_err_q[$];
    bit            psel_log[LOGN];
    bit            pen_log[LOGN];
    bit            pwrite_log[LOGN];
    logic [AW-1:0] paddr_log[LOGN];

    bit            c_wr[$];
    logic [AW-1:0] c_addr[$];
    logic [DW-1:0] c_wd[$];
    int            c_gap[$];

    int  slv_waits = 0;
    bit  slv_rand = 1'b0;
    bit  slv_hang = 1'b0;
    int  wcnt = 0;
    int  cur_waits = 0;
    logic [DW-1:0] slv_mem[int];
    logic [DW-1:0] ref_mem[int];

    function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
        return {a, 22'h0} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [DW-1:0] slv_read(input logic [AW-1:0] a);
        return slv_mem.exists(int'(a)) ? slv_mem[int'(a)] : mem_init(a);
    endfunction

    // Reference: in-order transfers against a plain word memory
    function automatic void model_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                       output logic [DW-1:0] erd, output logic eerr);
        eerr = (a == ERR_ADDR);
        if (!ref_mem.exists(int'(a))) ref_mem[int'(a)] = mem_init(a);
        if (wr) begin
            ref_mem[int'(a)] = wd;
            erd = '0;
        end else begin
            erd = ref_mem[int'(a)];
        end
    endfunction

    // Completer: random junk outside ACCESS, configurable wait states inside
    always @(negedge pclk) begin
        if (psel && penable) begin
            if (!slv_hang && wcnt >= cur_waits) begin
                pready  <= 1'b1;
                prdata  <= pwrite ? DW'($urandom) : slv_read(paddr);
                pslverr <= (paddr == ERR_ADDR);
            end else begin
                pready  <= 1'b0;
                prdata  <= DW'($urandom);
                pslverr <= 1'($urandom);
                wcnt    <= wcnt + 1;
            end
        end else begin
            wcnt      <= 0;
            cur_waits <= slv_rand ? int'($urandom_range(0, 3)) : slv_waits;
            pready    <= 1'($urandom);
            pslverr   <= 1'($urandom);
            prdata    <= DW'($urandom);
        end
    end

    always @(posedge pclk) begin
        if (psel && penable && pready && pwrite) slv_mem[int'(paddr)] = pwdata;
    end

    always @(posedge pclk) begin
        if (cyc < LOGN) begin
            psel_log[cyc]   <= psel;
            pen_log[cyc]    <= penable;
            pwrite_log[cyc] <= pwrite;
            paddr_log[cyc]  <= paddr;
        end
        if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
        if (rsp_valid) begin
            rsp_cyc_q.push_back(cyc);
            rsp_data_q.push_back(rsp_rdata);
            rsp_err_q.push_back(rsp_err);
        end
        cyc <= cyc + 1;
    end

    task automatic clear_logs();
        acc_q.delete();
        rsp_cyc_q.delete();
        rsp_data_q.delete();
        rsp_err_q.delete();
        c_wr.delete();
        c_addr.delete();
        c_wd.delete();
        c_gap.delete();
    endtask

    task automatic push_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd, input int gap);
        c_wr.push_back(wr);
        c_addr.push_back(a);
        c_wd.push_back(wd);
        c_gap.push_back(gap);
    endtask

    // Presents queued commands, keeping cmd_valid high between them when gap is 0
    task automatic drive_cmds();
        for (int i = 0; i < c_wr.size(); i++) begin
            bit ok;
            int guard;
            for (int g = 0; g < c_gap[i]; g++) begin
                @(negedge pclk);
                cmd_valid = 1'b0;
            end
            @(negedge pclk);
            cmd_valid = 1'b1;
            cmd_write = c_wr[i];
            cmd_addr  = c_addr[i];
            cmd_wdata = c_wd[i];
            ok = 1'b0;
            guard = 0;
            while (!ok && guard < 200) begin
                #3;
                ok = cmd_ready;
                @(posedge pclk);
                if (!ok) @(negedge pclk);
                guard++;
            end
            if (!ok) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: command %0d not accepted within %0d cycles", i, guard);
            end
        end
        @(negedge pclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsps(input int n, input int budget);
        for (int k = 0; k < budget && rsp_cyc_q.size() < n; k++) @(posedge pclk);
        #1;
        if (rsp_cyc_q.size() < n) begin
            tests++;
            fails++;
            $display("FAIL rsp_timeout: got %0d responses, want %0d", rsp_cyc_q.size(), n);
        end
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0 || paddr !== '0 || pwdata !== '0 || rsp_rdata !== '0) begin
            fails++;
            $display("FAIL reset_values: psel=%b penable=%b pwrite=%b rsp_valid=%b rsp_err=%b paddr=%h pwdata=%h rsp_rdata=%h, want all 0",
                     psel, penable, pwrite, rsp_valid, rsp_err, paddr, pwdata, rsp_rdata);
        end
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        #1;
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_write_read();
        logic [DW-1:0] erd;
        logic eerr;
        int a0, ps, pe;
        slv_rand = 1'b0; slv_waits = 0; slv_hang = 1'b0;
        clear_logs();
        push_cmd(1'b1, 10'h155, 32'hDEADBEEF, 0);
        drive_cmds();
        wait_rsps(1, 50);
        model_xfer(1'b1, 10'h155, 32'hDEADBEEF, erd, eerr);
        if (rsp_cyc_q.size() >= 1 && acc_q.size() >= 1) begin
            a0 = acc_q[0];
            ps = 0;
            pe = 0;
            for (int c = a0; c <= a0 + 4; c++) begin
                ps += int'(psel_log[c]);
                pe += int'(pen_log[c]);
            end
            tests++;
            if (rsp_cyc_q[0] - a0 !== 3) begin fails++; $display("FAIL wr_latency: got %0d want 3", rsp_cyc_q[0] - a0); end
            tests++;
            if (rsp_err_q[0] !== eerr || rsp_data_q[0] !== erd) begin
                fails++;
                $display("FAIL wr_rsp: err=%b rdata=%h want err=%b rdata=%h", rsp_err_q[0], rsp_data_q[0], eerr, erd);
            end
            tests++;
            if (ps !== 2 || pe !== 1) begin fails++; $display("FAIL wr_phases: psel cycles %0d penable cycles %0d, want 2 and 1", ps, pe); end
        end
        clear_logs();
        push_cmd(1'b0, 10'h155, 32'h0, 1);
        drive_cmds();
        wait_rsps(1, 50);
        model_xfer(1'b0, 10'h155, 32'h0, erd, eerr);
        if (rsp_cyc_q.size() >= 1 && acc_q.size() >= 1) begin
            tests++;
            if (rsp_data_q[0] !== 32'hDEADBEEF || rsp_data_q[0] !== erd || rsp_err_q[0] !== 1'b0) begin
                fails++;
                $display("FAIL rd_back: rdata=%h err=%b want rdata=%h err=0", rsp_data_q[0], rsp_err_q[0], erd);
            end
        end
        repeat (3) @(negedge pclk);
        tests++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL rsp_hold: rsp_valid=%b rsp_rdata=%h want 0 and deadbeef", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_wait_states();
        logic [DW-1:0] erd;
        logic eerr;
        logic [AW-1:0] a;
        int a0, unstable, pe;
        a = AW'($urandom_range(0, 63));
        slv_rand = 1'b0; slv_waits = 3; slv_hang = 1'b0;
        clear_logs();
        push_cmd(1'b0, a, 32'h0, 1);
        drive_cmds();
        wait_rsps(1, 50);
        model_xfer(1'b0, a, 32'h0, erd, eerr);
        if (rsp_cyc_q.size() >= 1 && acc_q.size() >= 1) begin
            a0 = acc_q[0];
            unstable = 0;
            pe = 0;
            for (int c = a0 + 1; c <= a0 + 5; c++) begin
                if (!psel_log[c] || pwrite_log[c] || paddr_log[c] !== a) unstable++;
                pe += int'(pen_log[c]);
            end
            tests++;
            if (rsp_cyc_q[0] - a0 !== 6) begin fails++; $display("FAIL wait_latency: got %0d want 6", rsp_cyc_q[0] - a0); end
            tests++;
            if (unstable !== 0 || pe !== 4) begin
                fails++;
                $display("FAIL wait_stable: unstable cycles %0d penable cycles %0d, want 0 and 4", unstable, pe);
            end
            tests++;
            if (rsp_data_q[0] !== erd || rsp_err_q[0] !== eerr) begin
                fails++;
                $display("FAIL wait_rdata: rdata=%h err=%b want %h %b", rsp_data_q[0], rsp_err_q[0], erd, eerr);
            end
        end
        slv_waits = 0;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] erd0, erd1, wd;
        logic eerr0, eerr1;
        logic [AW-1:0] a;
        int a0, low;
        a = AW'($urandom_range(64, 127));
        wd = DW'($urandom);
        slv_rand = 1'b0; slv_waits = 0; slv_hang = 1'b0;
        clear_logs();
        push_cmd(1'b1, a, wd, 1);
        push_cmd(1'b0, a, 32'h0, 0);
        drive_cmds();
        wait_rsps(2, 50);
        model_xfer(1'b1, a, wd, erd0, eerr0);
        model_xfer(1'b0, a, 32'h0, erd1, eerr1);
        if (rsp_cyc_q.size() >= 2 && acc_q.size() >= 2) begin
            a0 = acc_q[0];
            low = 0;
            for (int c = a0 + 1; c <= a0 + 4; c++) if (!psel_log[c]) low++;
            tests++;
            if (acc_q[1] - a0 !== 2 || rsp_cyc_q[1] - rsp_cyc_q[0] !== 2) begin
                fails++;
                $display("FAIL b2b_spacing: accept gap %0d rsp gap %0d, want 2 and 2", acc_q[1] - a0, rsp_cyc_q[1] - rsp_cyc_q[0]);
            end
            tests++;
            if (low !== 0) begin fails++; $display("FAIL b2b_psel: psel low for %0d cycles, want 0", low); end
            tests++;
            if (rsp_data_q[0] !== erd0 || rsp_err_q[0] !== eerr0 || rsp_data_q[1] !== erd1 || rsp_err_q[1] !== eerr1) begin
                fails++;
                $display("FAIL b2b_data: got %h/%b %h/%b want %h/%b %h/%b", rsp_data_q[0], rsp_err_q[0],
                         rsp_data_q[1], rsp_err_q[1], erd0, eerr0, erd1, eerr1);
            end
        end
    endtask

    task automatic test_slverr();
        logic [DW-1:0] erd0, erd1, wd;
        logic eerr0, eerr1;
        wd = DW'($urandom);
        slv_rand = 1'b0; slv_waits = 1; slv_hang = 1'b0;
        clear_logs();
        push_cmd(1'b1, ERR_ADDR, wd, 1);
        push_cmd(1'b1, 10'h020, ~wd, 0);
        drive_cmds();
        wait_rsps(2, 60);
        model_xfer(1'b1, ERR_ADDR, wd, erd0, eerr0);
        model_xfer(1'b1, 10'h020, ~wd, erd1, eerr1);
        if (rsp_cyc_q.size() >= 2) begin
            tests++;
            if (rsp_err_q[0] !== 1'b1 || rsp_err_q[0] !== eerr0 || rsp_data_q[0] !== erd0) begin
                fails++;
                $display("FAIL slverr_set: err=%b rdata=%h want 1 and %h", rsp_err_q[0], rsp_data_q[0], erd0);
            end
            tests++;
            if (rsp_err_q[1] !== 1'b0 || rsp_err_q[1] !== eerr1) begin
                fails++;
                $display("FAIL slverr_clear: err=%b want 0", rsp_err_q[1]);
            end
        end
        slv_waits = 0;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] erd, wd;
        logic eerr;
        int k;
        slv_rand = 1'b0; slv_waits = 0; slv_hang = 1'b1;
        clear_logs();
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h033;
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        for (k = 0; k < 10 && !penable; k++) @(negedge pclk);
        tests++;
        if (penable !== 1'b1) begin fails++; $display("FAIL rst_mid_access: penable=%b want 1 before reset", penable); end
        #1;
        preset = 1'b1;
        #1;
        tests++;
        if (psel !== 1'b0 || penable !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_drop: psel=%b penable=%b want 0 0", psel, penable);
        end
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        slv_hang = 1'b0;
        repeat (5) @(negedge pclk);
        tests++;
        if (rsp_cyc_q.size() !== 0) begin fails++; $display("FAIL rst_mid_norsp: %0d responses, want 0", rsp_cyc_q.size()); end
        clear_logs();
        wd = DW'($urandom);
        push_cmd(1'b1, 10'h034, wd, 0);
        drive_cmds();
        wait_rsps(1, 50);
        model_xfer(1'b1, 10'h034, wd, erd, eerr);
        if (rsp_cyc_q.size() >= 1 && acc_q.size() >= 1) begin
            tests++;
            if (rsp_cyc_q[0] - acc_q[0] !== 3 || rsp_err_q[0] !== eerr || rsp_data_q[0] !== erd) begin
                fails++;
                $display("FAIL rst_mid_fresh: latency %0d err=%b rdata=%h want 3 %b %h",
                         rsp_cyc_q[0] - acc_q[0], rsp_err_q[0], rsp_data_q[0], eerr, erd);
            end
        end
    endtask

    task automatic test_random();
        localparam int N = 24;
        logic [DW-1:0] erd;
        logic eerr;
        slv_rand = 1'b1; slv_hang = 1'b0;
        clear_logs();
        for (int i = 0; i < N; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 7) == 0) ? ERR_ADDR : AW'($urandom_range(0, 7));
            push_cmd(1'($urandom), a, DW'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
        end
        drive_cmds();
        wait_rsps(N, 400);
        repeat (4) @(negedge pclk);
        tests++;
        if (rsp_cyc_q.size() !== N) begin fails++; $display("FAIL rand_count: %0d responses want %0d", rsp_cyc_q.size(), N); end
        for (int i = 0; i < N && i < rsp_cyc_q.size(); i++) begin
            model_xfer(c_wr[i], c_addr[i], c_wd[i], erd, eerr);
            tests++;
            if (rsp_data_q[i] !== erd || rsp_err_q[i] !== eerr) begin
                fails++;
                $display("FAIL rand_rsp[%0d]: wr=%b addr=%h rdata=%h err=%b want %h %b",
                         i, c_wr[i], c_addr[i], rsp_data_q[i], rsp_err_q[i], erd, eerr);
            end
        end
        slv_rand = 1'b0;
    endtask

`ifdef APB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        logic [DW-1:0] erd;
        logic eerr;
        slv_rand = 1'b0; slv_waits = 0; slv_hang = 1'b1;
        clear_logs();
        push_cmd(1'b0, 10'h011, 32'h0, 1);
        drive_cmds();
        wait_rsps(1, 60);
        if (rsp_cyc_q.size() >= 1 && acc_q.size() >= 1) begin
            tests++;
            if (rsp_cyc_q[0] - acc_q[0] !== 19 || rsp_err_q[0] !== 1'b1 || rsp_data_q[0] !== '0) begin
                fails++;
                $display("FAIL timeout_rsp: latency %0d err=%b rdata=%h want 19 1 0",
                         rsp_cyc_q[0] - acc_q[0], rsp_err_q[0], rsp_data_q[0]);
            end
        end
        @(negedge pclk);
        #3;
        tests++;
        if (psel !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL timeout_idle: psel=%b cmd_ready=%b want 0 1", psel, cmd_ready);
        end
        slv_hang = 1'b0;
        slv_waits = 16;
        clear_logs();
        push_cmd(1'b0, 10'h012, 32'h0, 1);
        drive_cmds();
        wait_rsps(1, 60);
        model_xfer(1'b0, 10'h012, 32'h0, erd, eerr);
        if (rsp_cyc_q.size() >= 1 && acc_q.size() >= 1) begin
            tests++;
            if (rsp_cyc_q[0] - acc_q[0] !== 19 || rsp_err_q[0] !== eerr || rsp_data_q[0] !== erd) begin
                fails++;
                $display("FAIL timeout_race: latency %0d err=%b rdata=%h want 19 %b %h",
                         rsp_cyc_q[0] - acc_q[0], rsp_err_q[0], rsp_data_q[0], eerr, erd);
            end
        end
        slv_waits = 0;
    endtask
`endif

    initial begin
        #1;
        preset = 1'b1;
        test_reset();
        test_write_read();
        test_wait_states();
        test_back_to_back();
        test_slverr();
        test_reset_mid();
        test_random();
`ifdef APB_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge pclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
